// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, requester ids
// and the word-alignment helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      CORE = 1'b0,
      DBG  = 1'b1
   } req_id_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] adr_lsb);
      return (adr_lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: round-robin against last_grant, or debug-first when
// prio_mode is set. Purely combinational; the parent owns last_grant.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,        // bit 0 = core, bit 1 = debug
   input  req_id_t    last_grant_i,
   input  logic       prio_mode_i,
   output req_id_t    gnt_o,
   output logic       valid_o
);

   always_comb begin
      gnt_o   = CORE;
      valid_o = |req_i;
      case (req_i)
         2'b01:   gnt_o = CORE;
         2'b10:   gnt_o = DBG;
         2'b11: begin
            if (prio_mode_i)
               gnt_o = DBG;
            else
               gnt_o = (last_grant_i == CORE) ? DBG : CORE;
         end
         default: gnt_o = CORE;
      endcase
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one unified instruction/data memory between the core and a
// debug/loader port: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int DBG_PRIORITY = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_adr,
   input  logic [DW-1:0] core_wd,
   output logic          core_ack,
   output logic [DW-1:0] core_rd,
   output logic          core_err,
   output logic          core_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_adr,
   input  logic [DW-1:0] dbg_wd,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rd,
   output logic          dbg_err,
   input  logic          dbg_lock,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          busy
);

   localparam logic PRIO_MODE = (DBG_PRIORITY != 0);

   arb_state_t    state_q, state_d;
   req_id_t       last_grant_q, last_grant_d;
   req_id_t       id_q, id_d;
   logic          we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] wd_q, wd_d;
   logic [DW-1:0] core_rd_q, core_rd_d, dbg_rd_q, dbg_rd_d;
   logic          core_err_q, core_err_d, dbg_err_q, dbg_err_d;

   logic [1:0]    elig;
   req_id_t       gnt_id;
   logic          gnt_valid;
   logic          aligned;

   // The lock only masks the core at the sampling point; an in-flight core
   // transaction is already latched and runs to completion.
   assign elig    = {dbg_req, core_req & ~dbg_lock};
   assign aligned = is_aligned(adr_q[1:0]);

   rr_arb2 u_arb (
      .req_i        (elig),
      .last_grant_i (last_grant_q),
      .prio_mode_i  (PRIO_MODE),
      .gnt_o        (gnt_id),
      .valid_o      (gnt_valid)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      adr_d        = adr_q;
      wd_d         = wd_q;
      core_rd_d    = core_rd_q;
      core_err_d   = core_err_q;
      dbg_rd_d     = dbg_rd_q;
      dbg_err_d    = dbg_err_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d      = ACCESS;
               id_d         = gnt_id;
               last_grant_d = gnt_id;
               we_d         = (gnt_id == DBG) ? dbg_we  : core_we;
               adr_d        = (gnt_id == DBG) ? dbg_adr : core_adr;
               wd_d         = (gnt_id == DBG) ? dbg_wd  : core_wd;
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (id_q == CORE) begin
               core_rd_d  = aligned ? mem_rd : '0;
               core_err_d = ~aligned;
            end else begin
               dbg_rd_d   = aligned ? mem_rd : '0;
               dbg_err_d  = ~aligned;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= DBG;
         id_q         <= CORE;
         we_q         <= 1'b0;
         adr_q        <= '0;
         wd_q         <= '0;
         core_rd_q    <= '0;
         core_err_q   <= 1'b0;
         dbg_rd_q     <= '0;
         dbg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         adr_q        <= adr_d;
         wd_q         <= wd_d;
         core_rd_q    <= core_rd_d;
         core_err_q   <= core_err_d;
         dbg_rd_q     <= dbg_rd_d;
         dbg_err_q    <= dbg_err_d;
      end
   end

   // Acks and mem_we decode straight from state so reset kills them at once.
   assign core_ack   = (state_q == RESP) && (id_q == CORE);
   assign dbg_ack    = (state_q == RESP) && (id_q == DBG);
   assign core_rd    = core_rd_q;
   assign core_err   = core_err_q;
   assign dbg_rd     = dbg_rd_q;
   assign dbg_err    = dbg_err_q;
   assign core_stall = core_req & ~core_ack;
   assign mem_we     = (state_q == ACCESS) & we_q & aligned;
   assign mem_adr    = {adr_q[AW-1:2], 2'b00};
   assign mem_wd     = wd_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: round-robin instance (a) and debug-priority instance (b),
// each backed by a small combinational-read word memory.
module tb_unified_mem_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance a: DBG_PRIORITY = 0
   logic        core_req_a = 0, core_we_a = 0, dbg_req_a = 0, dbg_we_a = 0, dbg_lock_a = 0;
   logic [31:0] core_adr_a = 0, core_wd_a = 0, dbg_adr_a = 0, dbg_wd_a = 0;
   logic        core_ack_a, core_err_a, core_stall_a, dbg_ack_a, dbg_err_a, mem_we_a, busy_a;
   logic [31:0] core_rd_a, dbg_rd_a, mem_adr_a, mem_wd_a, mem_rd_a;
   logic [31:0] mem_a [0:63];

   // instance b: DBG_PRIORITY = 1
   logic        core_req_b = 0, dbg_req_b = 0;
   logic [31:0] core_adr_b = 32'h10, dbg_adr_b = 32'h0;
   logic        core_ack_b, core_err_b, core_stall_b, dbg_ack_b, dbg_err_b, mem_we_b, busy_b;
   logic [31:0] core_rd_b, dbg_rd_b, mem_adr_b, mem_wd_b, mem_rd_b;
   logic [31:0] mem_b [0:63];

   unified_mem_arbiter #(.AW(32), .DW(32), .DBG_PRIORITY(0)) dut_a (
      .clk(clk), .reset(reset),
      .core_req(core_req_a), .core_we(core_we_a), .core_adr(core_adr_a), .core_wd(core_wd_a),
      .core_ack(core_ack_a), .core_rd(core_rd_a), .core_err(core_err_a), .core_stall(core_stall_a),
      .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_adr(dbg_adr_a), .dbg_wd(dbg_wd_a),
      .dbg_ack(dbg_ack_a), .dbg_rd(dbg_rd_a), .dbg_err(dbg_err_a), .dbg_lock(dbg_lock_a),
      .mem_we(mem_we_a), .mem_adr(mem_adr_a), .mem_wd(mem_wd_a), .mem_rd(mem_rd_a), .busy(busy_a)
   );

   unified_mem_arbiter #(.AW(32), .DW(32), .DBG_PRIORITY(1)) dut_b (
      .clk(clk), .reset(reset),
      .core_req(core_req_b), .core_we(1'b0), .core_adr(core_adr_b), .core_wd(32'h0),
      .core_ack(core_ack_b), .core_rd(core_rd_b), .core_err(core_err_b), .core_stall(core_stall_b),
      .dbg_req(dbg_req_b), .dbg_we(1'b0), .dbg_adr(dbg_adr_b), .dbg_wd(32'h0),
      .dbg_ack(dbg_ack_b), .dbg_rd(dbg_rd_b), .dbg_err(dbg_err_b), .dbg_lock(1'b0),
      .mem_we(mem_we_b), .mem_adr(mem_adr_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b), .busy(busy_b)
   );

   assign mem_rd_a = mem_a[mem_adr_a[7:2]];
   assign mem_rd_b = mem_b[mem_adr_b[7:2]];

   always @(posedge clk) begin
      if (mem_we_a) mem_a[mem_adr_a[7:2]] <= mem_wd_a;
      if (mem_we_b) mem_b[mem_adr_b[7:2]] <= mem_wd_b;
   end

   // Protocol monitors sampled mid-cycle.
   int we_seen_a = 0;
   int lock_ack_a = 0;
   int lock_nostall_a = 0;
   always @(negedge clk) begin
      if (mem_we_a) we_seen_a++;
      if (dbg_lock_a && core_ack_a) lock_ack_a++;
      if (dbg_lock_a && core_req_a && !core_stall_a) lock_nostall_a++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_core_ack(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (core_ack_a) break;
      end
      if (!core_ack_a) check("core_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_dbg_ack(output int lat);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (dbg_ack_a) break;
      end
      if (!dbg_ack_a) check("dbg_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic core_txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output int lat);
      core_we_a  = we;
      core_adr_a = adr;
      core_wd_a  = wd;
      core_req_a = 1'b1;
      wait_core_ack(lat);
      core_req_a = 1'b0;
   endtask

   task automatic dbg_txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          output int lat);
      dbg_we_a  = we;
      dbg_adr_a = adr;
      dbg_wd_a  = wd;
      dbg_req_a = 1'b1;
      wait_dbg_ack(lat);
      dbg_req_a = 1'b0;
   endtask

   initial begin
      int lat;
      int bad;
      logic [1:0] exp_acks;

      for (int i = 0; i < 64; i++) begin
         mem_a[i] = 32'h1000_0000 + i;
         mem_b[i] = 32'h2000_0000 + i;
      end
      mem_a[4] = 32'hDEADBEEF;
      mem_a[1] = 32'hCAFEF00D;
      mem_a[2] = 32'h11112222;

      // reset state
      #2;
      check("rst_core_ack", {31'b0, core_ack_a}, 32'd0);
      check("rst_dbg_ack",  {31'b0, dbg_ack_a},  32'd0);
      check("rst_busy",     {31'b0, busy_a},     32'd0);
      check("rst_mem_we",   {31'b0, mem_we_a},   32'd0);
      check("rst_core_rd",  core_rd_a, 32'd0);
      check("rst_dbg_rd",   dbg_rd_a,  32'd0);
      check("rst_err",      {30'b0, core_err_a, dbg_err_a}, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // single core read
      we_seen_a = 0;
      core_txn(1'b0, 32'h10, 32'h0, lat);
      check("rd_latency", lat, 32'd2);
      check("rd_data",    core_rd_a, 32'hDEADBEEF);
      check("rd_err",     {31'b0, core_err_a}, 32'd0);
      check("rd_dbg_ack", {31'b0, dbg_ack_a},  32'd0);
      tick();
      check("rd_no_we",   we_seen_a, 32'd0);
      check("rd_idle",    {31'b0, busy_a}, 32'd0);

      // debug lock preload
      lock_ack_a = 0;
      lock_nostall_a = 0;
      dbg_lock_a = 1'b1;
      core_we_a  = 1'b0;
      core_adr_a = 32'h0;
      core_req_a = 1'b1;
      dbg_txn(1'b1, 32'h0, 32'h00500113, lat);
      check("lock_dbg_latency", lat, 32'd2);
      check("lock_dbg_err", {31'b0, dbg_err_a}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("lock_no_core_ack", lock_ack_a, 32'd0);
      check("lock_stall", lock_nostall_a, 32'd0);
      check("lock_mem_word", mem_a[0], 32'h00500113);
      dbg_lock_a = 1'b0;
      wait_core_ack(lat);
      core_req_a = 1'b0;
      check("unlock_latency", lat, 32'd2);
      check("unlock_rd", core_rd_a, 32'h00500113);
      tick();

      // misaligned store
      we_seen_a = 0;
      core_txn(1'b1, 32'h06, 32'h1234, lat);
      check("mis_latency", lat, 32'd2);
      check("mis_err", {31'b0, core_err_a}, 32'd1);
      check("mis_rd",  core_rd_a, 32'd0);
      tick();
      check("mis_no_we", we_seen_a, 32'd0);
      check("mis_mem", mem_a[1], 32'hCAFEF00D);
      check("mis_err_hold", {31'b0, core_err_a}, 32'd1);
      core_txn(1'b0, 32'h10, 32'h0, lat);
      check("mis_err_clear", {31'b0, core_err_a}, 32'd0);
      check("mis_rd_after", core_rd_a, 32'hDEADBEEF);
      tick();

      // round-robin contention from reset
      pulse_reset();
      core_we_a = 1'b0; core_adr_a = 32'h10;
      dbg_we_a  = 1'b0; dbg_adr_a  = 32'h0;
      core_req_a = 1'b1;
      dbg_req_a  = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         exp_acks = (t == 2 || t == 8) ? 2'b10 : (t == 5 || t == 11) ? 2'b01 : 2'b00;
         check($sformatf("rr_acks_t%0d", t), {30'b0, core_ack_a, dbg_ack_a}, {30'b0, exp_acks});
      end
      core_req_a = 1'b0;
      dbg_req_a  = 1'b0;
      tick();

      // reset during a debug write's ACCESS cycle
      dbg_we_a  = 1'b1;
      dbg_adr_a = 32'h8;
      dbg_wd_a  = 32'h55;
      dbg_req_a = 1'b1;
      tick();
      check("mid_we_before", {31'b0, mem_we_a}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid_we_drop", {31'b0, mem_we_a}, 32'd0);
      check("mid_busy",    {31'b0, busy_a},   32'd0);
      dbg_req_a = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dbg_ack_a) bad++;
      end
      check("mid_no_ack", bad, 32'd0);
      check("mid_mem", mem_a[2], 32'h11112222);
      reset = 1'b1;
      core_we_a = 1'b0; core_adr_a = 32'h10;
      dbg_we_a  = 1'b0; dbg_adr_a  = 32'h0;
      core_req_a = 1'b1;
      dbg_req_a  = 1'b1;
      tick();
      tick();
      check("mid_tie_core", {30'b0, core_ack_a, dbg_ack_a}, 32'b10);
      core_req_a = 1'b0;
      dbg_req_a  = 1'b0;
      tick();

      // fixed debug priority
      pulse_reset();
      core_req_b = 1'b1;
      dbg_req_b  = 1'b1;
      for (int t = 1; t <= 11; t++) begin
         tick();
         exp_acks = (t == 2 || t == 5 || t == 8) ? 2'b01 : (t == 11) ? 2'b10 : 2'b00;
         check($sformatf("prio_acks_t%0d", t), {30'b0, core_ack_b, dbg_ack_b}, {30'b0, exp_acks});
         if (t == 8) dbg_req_b = 1'b0;
      end
      check("prio_core_rd", core_rd_b, 32'h2000_0004);
      core_req_b = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle RISC-V system between two requesters: the core (fetch and load/store traffic) and a debug/loader port. The loader port preloads programs and inspects memory.
- Sits in top_multi_cycle between the core's memory interface and the memory instance.
- Handles request/acknowledge sequencing, round-robin or fixed-priority arbitration, a debug lock, and misaligned-access error reporting.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- DBG_PRIORITY, 0: 0 = round-robin between core and debug; 1 = debug always wins ties.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- core_req  input  1  core request; held with its fields until core_ack.
- core_we  input  1  core write enable (1 = store).
- core_adr  input  AW  core byte address.
- core_wd  input  DW  core write data.
- core_ack  output  1  one-cycle completion pulse to the core.
- core_rd  output  DW  read data; valid when core_ack = 1.
- core_err  output  1  misaligned-access flag; valid when core_ack = 1.
- core_stall  output  1  core_req & ~core_ack (used to freeze the core FSM).
- dbg_req, dbg_we, dbg_adr, dbg_wd  inputs  1/1/AW/DW  debug request fields, same rules as the core port.
- dbg_ack, dbg_rd, dbg_err  outputs  1/DW/1  debug response fields, same rules as the core port.
- dbg_lock  input  1  while high, core requests are never granted.
- mem_we  output  1  memory write enable.
- mem_adr  output  AW  word-aligned memory address ({adr[AW-1:2],2'b00}).
- mem_wd  output  DW  memory write data.
- mem_rd  input  DW  combinational memory read data.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state = IDLE; all ack, err, mem_we and busy outputs = 0; core_rd and dbg_rd = 0.
  - last_grant = DBG, so the core wins the first tie.
  - Reset mid-transaction abandons it: no ack is issued, and mem_we drops immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample the eligible requests: core_req & ~dbg_lock, and dbg_req.
  - If no request is eligible, stay in IDLE.
  - If one request is eligible, grant it.
  - If both are eligible:
    - DBG_PRIORITY = 1 → debug wins.
    - DBG_PRIORITY = 0 → the requester other than last_grant wins.
  - On a grant: latch id, we, adr and wd into registers, update last_grant, and go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_adr and mem_wd are driven from the latched fields.
  - mem_we = latched_we & aligned, where aligned = (latched_adr[1:0] == 0).
  - The edge that ends ACCESS captures mem_rd into the granted requester's rd register; the memory write commits on the same edge.
  - Misaligned access: no write, rd register = 0, err flag set.
  - Go to RESP.
- RESP (exactly one cycle):
  - Assert the granted requester's ack, with its err flag if set.
  - The other requester's ack stays 0.
  - Then go to IDLE.
- Latency: request sampled in IDLE on cycle N → ack on cycle N+2. Peak throughput is one transaction per 3 cycles.
- Outside ACCESS: mem_we = 0; mem_adr and mem_wd hold their last latched values.
- rd and err registers hold their values until that requester's next completed transaction.
- Requester rules:
  - A request must stay high until its ack; dropping it early is ignored, because the fields are already latched and ack still pulses.
  - req still high in the IDLE cycle after ack is treated as a new request.
- dbg_lock:
  - Sampled only in IDLE. Asserting it during an in-flight core transaction does not abort that transaction.
  - While locked, a core request waits and core_stall stays high.
- Write data passes through unmodified; no byte enables (word accesses only).

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ACCESS, RESP}.
  - req_id_t enum {CORE, DBG}.
  - Localparams for the alignment mask.
- Sub-module rr_arb2: a 2-way round-robin/priority picker.
  - Inputs: req[1:0], last_grant, prio_mode.
  - Output: gnt id plus a valid flag.
  - Purely combinational; last_grant is a register in the parent.

Test Plan:
- Single core read: memory word 0x10 = 0xDEADBEEF; core_req with core_adr = 0x10 on cycle N → core_ack on N+2, core_rd = 0xDEADBEEF, mem_we never high.
- Contention, round-robin (DBG_PRIORITY = 0): core and debug requests held continuously from reset → grant order CORE, DBG, CORE, DBG; acks on cycles 2, 5, 8, 11 after the first sample.
- Debug lock preload: dbg_lock = 1, debug writes 0x00500113 to address 0; core_req held → core_ack stays 0 and core_stall stays 1. Drop the lock → core is granted; core read of address 0 returns 0x00500113.
- Misaligned store: core_we = 1, core_adr = 0x06, core_wd = 0x1234 → mem_we stays 0; core_ack with core_err = 1 and core_rd = 0; memory word 0x04 is unchanged.
- Reset mid-operation: assert reset during ACCESS of a debug write → mem_we falls immediately, no dbg_ack. After release, a core/debug tie grants CORE first.
- Fixed priority (DBG_PRIORITY = 1): both requests held → three consecutive DBG grants while dbg_req stays high; core granted only once dbg_req drops.
